// File: rtl/axis_hbin2.sv
// rtl/axis_hbin2.sv - AXI-Stream horizontal 2:1 pixel binning stage
// Adjacent pixel pairs in a line are averaged into one output pixel; user/last markers are preserved.
module axis_hbin2 #(
  parameter int PIXEL_BITS = 8,
  parameter int ROUND      = 1,
  parameter int CNT_BITS   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [PIXEL_BITS-1:0] axis_s_data_i,
  input  logic                  axis_s_valid_i,
  output logic                  axis_s_ready_o,
  input  logic                  axis_s_last_i,
  input  logic                  axis_s_user_i,
  output logic [PIXEL_BITS-1:0] axis_m_data_o,
  output logic                  axis_m_valid_o,
  input  logic                  axis_m_ready_i,
  output logic                  axis_m_last_o,
  output logic                  axis_m_user_o,
  output logic [CNT_BITS-1:0]   drop_cnt_o
);

  typedef enum logic {ST_EMPTY, ST_HOLD} state_e;

  localparam logic [PIXEL_BITS:0] RND = {{PIXEL_BITS{1'b0}}, (ROUND != 0)};

  state_e                state_q, state_d;
  logic [PIXEL_BITS-1:0] hold_data_q, hold_data_d;
  logic                  hold_user_q, hold_user_d;
  logic [PIXEL_BITS-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic                  m_user_q, m_user_d;
  logic [CNT_BITS-1:0]   drop_cnt_q, drop_cnt_d;

  logic                  accept;
  logic [PIXEL_BITS:0]   sum;

  assign axis_s_ready_o = !rst_i && (!m_valid_q || axis_m_ready_i);
  assign accept         = axis_s_valid_i && axis_s_ready_o;
  assign sum            = {1'b0, hold_data_q} + {1'b0, axis_s_data_i} + RND;

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_user_d = hold_user_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    m_user_d    = m_user_q;
    drop_cnt_d  = drop_cnt_q;

    if (m_valid_q && axis_m_ready_i) begin
      m_valid_d = 1'b0;
    end

    if (accept) begin
      if (state_q == ST_HOLD && !axis_s_user_i) begin
        m_data_d  = sum[PIXEL_BITS:1];
        m_last_d  = axis_s_last_i;
        m_user_d  = hold_user_q;
        m_valid_d = 1'b1;
        state_d   = ST_EMPTY;
      end else begin
        // A start-of-frame arriving mid-pair orphans the held pixel.
        if (state_q == ST_HOLD && drop_cnt_q != {CNT_BITS{1'b1}}) begin
          drop_cnt_d = drop_cnt_q + CNT_BITS'(1);
        end
        if (axis_s_last_i) begin
          m_data_d  = axis_s_data_i;
          m_last_d  = 1'b1;
          m_user_d  = axis_s_user_i;
          m_valid_d = 1'b1;
          state_d   = ST_EMPTY;
        end else begin
          hold_data_d = axis_s_data_i;
          hold_user_d = axis_s_user_i;
          state_d     = ST_HOLD;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      hold_data_q <= '0;
      hold_user_q <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_user_q    <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_user_q <= hold_user_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_user_q    <= m_user_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign axis_m_data_o  = m_data_q;
  assign axis_m_valid_o = m_valid_q;
  assign axis_m_last_o  = m_last_q;
  assign axis_m_user_o  = m_user_q;
  assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_axis_hbin2.sv
// tb/tb_axis_hbin2.sv - scoreboard bench for axis_hbin2
// Two instances share stimulus: rounding with a 16-bit counter, truncating with a 2-bit counter.
module tb_axis_hbin2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_user = 1'b0;
  logic       m_ready = 1'b1;

  logic [7:0]  m_data1, m_data0;
  logic        m_valid1, m_valid0, m_last1, m_last0, m_user1, m_user0;
  logic        s_ready1, s_ready0;
  logic [15:0] drop1;
  logic [1:0]  drop0;

  int n_chk  = 0;
  int n_pass = 0;

  logic [9:0] exp1[$];
  logic [9:0] exp0[$];

  always #5 clk = ~clk;

  axis_hbin2 #(.PIXEL_BITS(8), .ROUND(1), .CNT_BITS(16)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .axis_s_data_i(s_data), .axis_s_valid_i(s_valid), .axis_s_ready_o(s_ready1),
    .axis_s_last_i(s_last), .axis_s_user_i(s_user),
    .axis_m_data_o(m_data1), .axis_m_valid_o(m_valid1), .axis_m_ready_i(m_ready),
    .axis_m_last_o(m_last1), .axis_m_user_o(m_user1), .drop_cnt_o(drop1)
  );

  axis_hbin2 #(.PIXEL_BITS(8), .ROUND(0), .CNT_BITS(2)) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .axis_s_data_i(s_data), .axis_s_valid_i(s_valid), .axis_s_ready_o(s_ready0),
    .axis_s_last_i(s_last), .axis_s_user_i(s_user),
    .axis_m_data_o(m_data0), .axis_m_valid_o(m_valid0), .axis_m_ready_i(m_ready),
    .axis_m_last_o(m_last0), .axis_m_user_o(m_user0), .drop_cnt_o(drop0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [9:0] beat(input logic u, input logic l, input logic [7:0] d);
    return {u, l, d};
  endfunction

  task automatic push(input logic u, input logic l, input logic [7:0] d1, input logic [7:0] d0);
    exp1.push_back(beat(u, l, d1));
    exp0.push_back(beat(u, l, d0));
  endtask

  // Drives one beat from a falling edge and returns just after the rising edge that accepts it.
  task automatic send(input logic [7:0] d, input logic u, input logic l);
    bit done = 1'b0;
    @(negedge clk);
    s_data = d; s_user = u; s_last = l; s_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (s_ready1) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk("send_timeout", {31'd0, s_ready1}, 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && (exp1.size() != 0 || exp0.size() != 0); i++) @(negedge clk);
    chk("drain_r1", exp1.size(), 0);
    chk("drain_r0", exp0.size(), 0);
  endtask

  // Output handshakes complete at the next rising edge; sample them late in the low phase.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && m_ready) begin
        if (m_valid1) begin
          if (exp1.size() == 0) chk("r1_unexpected", {22'd0, beat(m_user1, m_last1, m_data1)}, 32'hffff_ffff);
          else chk("r1_beat", {22'd0, beat(m_user1, m_last1, m_data1)}, {22'd0, exp1.pop_front()});
        end
        if (m_valid0) begin
          if (exp0.size() == 0) chk("r0_unexpected", {22'd0, beat(m_user0, m_last0, m_data0)}, 32'hffff_ffff);
          else chk("r0_beat", {22'd0, beat(m_user0, m_last0, m_data0)}, {22'd0, exp0.pop_front()});
        end
      end
    end
  end

  initial begin
    bit rnd_done;
    logic [7:0] px[8];
    int len;
    logic u;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", {31'd0, s_ready1}, 32'd0);
    chk("rst_valid", {31'd0, m_valid1 | m_valid0}, 32'd0);
    chk("rst_data", {16'd0, m_data1, m_data0}, 32'd0);
    chk("rst_flags", {28'd0, m_last1, m_user1, m_last0, m_user0}, 32'd0);
    chk("rst_drop", {14'd0, drop1, drop0}, 32'd0);
    rst = 1'b0;

    // Even line with one-cycle latency checks.
    push(1'b1, 1'b0, 8'd15, 8'd15);
    push(1'b0, 1'b1, 8'd36, 8'd35);
    send(8'd10, 1'b1, 1'b0);
    #1 chk("lat_before", {31'd0, m_valid1}, 32'd0);
    send(8'd20, 1'b0, 1'b0);
    #1 chk("lat_after", {31'd0, m_valid1}, 32'd1);
    send(8'd30, 1'b0, 1'b0);
    send(8'd41, 1'b0, 1'b1);
    #1 chk("lat_last", {31'd0, m_valid1}, 32'd1);

    // Odd line, then a fresh pairing on the next line.
    push(1'b0, 1'b0, 8'd101, 8'd101);
    push(1'b0, 1'b1, 8'd7, 8'd7);
    push(1'b0, 1'b1, 8'd3, 8'd3);
    send(8'd100, 1'b0, 1'b0);
    send(8'd102, 1'b0, 1'b0);
    send(8'd7, 1'b0, 1'b1);
    send(8'd2, 1'b0, 1'b0);
    send(8'd4, 1'b0, 1'b1);
    idle();
    drain();

    // Backpressure with an output pending.
    push(1'b0, 1'b0, 8'd2, 8'd2);
    push(1'b0, 1'b1, 8'd7, 8'd6);
    m_ready = 1'b0;
    send(8'd1, 1'b0, 1'b0);
    send(8'd3, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", {31'd0, s_ready1 | s_ready0}, 32'd0);
      chk("bp_hold", {22'd0, m_valid1, beat(m_user1, m_last1, m_data1)}, {22'd0, 1'b1, beat(1'b0, 1'b0, 8'd2)});
      @(negedge clk);
    end
    m_ready = 1'b1;
    send(8'd5, 1'b0, 1'b0);
    send(8'd8, 1'b0, 1'b1);
    idle();
    drain();

    // Stray start-of-frame mid-pair.
    push(1'b1, 1'b1, 8'd65, 8'd65);
    send(8'd50, 1'b1, 1'b0);
    send(8'd60, 1'b1, 1'b0);
    send(8'd70, 1'b0, 1'b1);
    idle();
    drain();
    chk("stray_drop1", {16'd0, drop1}, 32'd1);
    chk("stray_drop0", {30'd0, drop0}, 32'd1);

    // Rounding extremes.
    push(1'b0, 1'b0, 8'd255, 8'd255);
    push(1'b0, 1'b1, 8'd1, 8'd0);
    send(8'd255, 1'b0, 1'b0);
    send(8'd255, 1'b0, 1'b0);
    send(8'd0, 1'b0, 1'b0);
    send(8'd1, 1'b0, 1'b1);
    idle();
    drain();

    // Reset with a pixel held.
    send(8'd40, 1'b0, 1'b0);
    idle();
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_out", {20'd0, m_valid1, m_valid0, m_data1, m_data0, s_ready1, s_ready0}, 32'd0);
    chk("mid_rst_drop", {14'd0, drop1, drop0}, 32'd0);
    rst = 1'b0;
    push(1'b0, 1'b1, 8'd10, 8'd10);
    send(8'd8, 1'b0, 1'b0);
    send(8'd12, 1'b0, 1'b1);
    idle();
    drain();

    // Four strays: the 2-bit counter saturates at 3.
    for (int k = 0; k < 4; k++) begin
      push(1'b1, 1'b1, 8'(k + 200), 8'(k + 200));
      send(8'(k), 1'b1, 1'b0);
      send(8'(k + 200), 1'b1, 1'b1);
    end
    idle();
    drain();
    chk("sat_drop1", {16'd0, drop1}, 32'd4);
    chk("sat_drop0", {30'd0, drop0}, 32'd3);

    // Random lines under random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int ln = 0; ln < 40; ln++) begin
          len = $urandom_range(1, 7);
          u = (ln % 4 == 0);
          for (int j = 0; j < len; j++) px[j] = 8'($urandom_range(0, 255));
          for (int j = 0; j + 1 < len; j += 2)
            push(u && j == 0, (j + 2 == len),
                 8'((9'(px[j]) + 9'(px[j+1]) + 9'd1) >> 1), 8'((9'(px[j]) + 9'(px[j+1])) >> 1));
          if (len % 2 == 1) push(u && len == 1, 1'b1, px[len-1], px[len-1]);
          for (int j = 0; j < len; j++) send(px[j], u && j == 0, j == len - 1);
        end
        idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          m_ready = ($urandom_range(0, 3) != 0);
        end
        m_ready = 1'b1;
      end
    join
    drain();
    chk("end_drop1", {16'd0, drop1}, 32'd4);
    chk("end_drop0", {30'd0, drop0}, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
